rx_data_sampler: RTL and testbench
==================================

RX_DATA_SAMPLER -- requirements
Module: rx_data_sampler

Interface
REQ-001 Parameter PRESC_W, default 6, width of prescale input.
REQ-002 Parameter BITCNT_W, default 4, width of bit counter output.
REQ-003 CLK  input  1  receiver oversampling clock; all state on rising edge.
REQ-004 RST  input  1  asynchronous reset, active-high.
REQ-005 RX_IN  input  1  raw serial line, asynchronous to CLK, idle high.
REQ-006 prescale  input  PRESC_W  oversampling ratio; legal values 8, 16, 32.
REQ-007 dat_samp_en  input  1  enable from RX FSM; high for the whole frame.
REQ-008 sampled_bit  output  1  majority-voted bit value; feeds start/parity/stop checkers and deserializer.
REQ-009 samp_valid  output  1  one-cycle strobe; sampled_bit is new this cycle.
REQ-010 bit_end  output  1  one-cycle strobe on the last oversample tick of each bit.
REQ-011 bit_cnt  output  BITCNT_W  index of the bit currently being sampled, 0 = start bit.

Function
REQ-012 RX_IN passes through a 2-flop synchronizer before any use; this 2-cycle latency is part of the timing contract.
REQ-013 On the cycle dat_samp_en rises, prescale is latched into a shadow register; prescale changes mid-frame are ignored.
REQ-014 A latched value other than 8, 16 or 32 is treated as 8.
REQ-015 Edge counter edge_cnt (PRESC_W bits) runs 0..P-1 while enabled (P = latched prescale), wrapping to 0 after P-1.
REQ-016 bit_cnt increments when edge_cnt wraps; it wraps 2^BITCNT_W-1 -> 0 with no saturation.
REQ-017 bit_end is high exactly when edge_cnt == P-1.
REQ-018 Three samples of the synchronized line are captured, at edge_cnt == P/2-1, P/2 and P/2+1.
REQ-019 At edge_cnt == P/2+2, sampled_bit is loaded with the majority of the three samples and samp_valid pulses for one cycle.
REQ-020 sampled_bit holds its value between samp_valid strobes.
REQ-021 While dat_samp_en is low: edge_cnt, bit_cnt, sample registers, samp_valid and bit_end are 0; sampled_bit is 1 (idle level).
REQ-022 If dat_samp_en falls mid-bit, the next cycle returns all state to the REQ-021 values with no strobe; a later re-enable starts at edge_cnt 0 and bit_cnt 0.
REQ-023 When dat_samp_en rises, edge_cnt is 0 on the first enabled cycle.
REQ-024 samp_valid and bit_end never assert in the same cycle, since P/2+2 < P-1 for all legal P.

Reset
REQ-025 RST high asynchronously forces: synchronizer flops 1, sampled_bit 1, samp_valid 0, bit_end 0, bit_cnt 0, edge_cnt 0, prescale shadow 8.
REQ-026 On release of RST, the first active edge behaves per REQ-021/023 based on dat_samp_en.

Structure
REQ-027 Constants PRESC_8, PRESC_16, PRESC_32 and idle line level belong in the shared UART RX package.
REQ-028 The synchronizer is one sub-module, bit_sync (parameterised stages, default 2, reset value 1).
REQ-029 The majority vote is combinational inside rx_data_sampler.
REQ-030 Target size is 120-400 RTL lines.

Verification
REQ-031 prescale=8, RX_IN held 0, dat_samp_en raised: first samp_valid at enabled cycle 6 with sampled_bit=0; bit_end at cycle 7; bit_cnt=1 at cycle 8.
REQ-032 prescale=16, single-cycle 1-glitch on the synchronized line at edge_cnt=8 within a 0 bit: sampled_bit=0 (majority 2:1).
REQ-033 prescale=32, 11 bits 0,1,0,1,...: samp_valid at edge_cnt=18 of each bit with the correct value; bit_cnt steps 0..10; bit_cnt wraps 15->0 on a 17-bit run.
REQ-034 dat_samp_en dropped at edge_cnt=5 (P=16): next cycle all counters 0 and sampled_bit=1 with no strobe; re-enable restarts at bit 0.
REQ-035 prescale changed 8->16 mid-frame: timing stays P=8 until re-enable; prescale=12 latched behaves as 8.
REQ-036 RST asserted mid-frame asynchronously: outputs take REQ-025 values without waiting for a CLK edge.

Source files
------------

// File: rtl/rx_data_sampler_pkg.sv
// Shared UART RX constants: legal oversampling ratios and the idle line level.
package rx_data_sampler_pkg;

  localparam int PRESC_8  = 8;
  localparam int PRESC_16 = 16;
  localparam int PRESC_32 = 32;

  localparam logic IDLE_LEVEL = 1'b1;

  function automatic logic isLegalPresc(input int unsigned p);
    return (p == PRESC_8) || (p == PRESC_16) || (p == PRESC_32);
  endfunction

endpackage

// File: rtl/rx_data_sampler_bit_sync.sv
// Multi-stage flop synchronizer for a single asynchronous bit.
module bit_sync
  import rx_data_sampler_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = IDLE_LEVEL
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/rx_data_sampler.sv
// Oversampling RX bit sampler: times each bit with an edge counter and
// majority-votes three mid-bit samples of the synchronized line.
module rx_data_sampler
  import rx_data_sampler_pkg::*;
#(
  parameter int PRESC_W  = 6,
  parameter int BITCNT_W = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                RX_IN,
  input  logic [PRESC_W-1:0]  prescale,
  input  logic                dat_samp_en,
  output logic                sampled_bit,
  output logic                samp_valid,
  output logic                bit_end,
  output logic [BITCNT_W-1:0] bit_cnt
);

  localparam logic [PRESC_W-1:0]  P_ONE = PRESC_W'(1);
  localparam logic [PRESC_W-1:0]  P_DEF = PRESC_W'(PRESC_8);
  localparam logic [BITCNT_W-1:0] B_ONE = BITCNT_W'(1);

  logic                r_enD;
  logic [PRESC_W-1:0]  r_presc;
  logic [PRESC_W-1:0]  r_edgeCnt;
  logic [BITCNT_W-1:0] r_bitCnt;
  logic                r_samp0;
  logic                r_samp1;
  logic                r_sampledBit;
  logic                r_sampValid;
  logic                r_bitEnd;

  logic                w_sync;
  logic [PRESC_W-1:0]  w_prescIn;
  logic [PRESC_W-1:0]  w_p;
  logic [PRESC_W-1:0]  w_half;
  logic [PRESC_W-1:0]  w_last;
  logic                w_wrap;
  logic [PRESC_W-1:0]  w_cntNxt;
  logic                w_maj;

  bit_sync #(
    .STAGES  (2),
    .RST_VAL (IDLE_LEVEL)
  ) u_sync (
    .i_clk (CLK),
    .i_rst (RST),
    .i_d   (RX_IN),
    .o_q   (w_sync)
  );

  // On the enabling cycle the shadow is not yet loaded, so use the live input.
  assign w_prescIn = isLegalPresc(int'(prescale)) ? prescale : P_DEF;
  assign w_p       = r_enD ? r_presc : w_prescIn;
  assign w_half    = w_p >> 1;
  assign w_last    = w_p - P_ONE;
  assign w_wrap    = (r_edgeCnt == w_last);
  assign w_cntNxt  = w_wrap ? '0 : (r_edgeCnt + P_ONE);

  // Third sample is the live synchronized line, voted in the cycle it is taken.
  assign w_maj = (r_samp0 & r_samp1) | (r_samp0 & w_sync) | (r_samp1 & w_sync);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_enD        <= 1'b0;
      r_presc      <= P_DEF;
      r_edgeCnt    <= '0;
      r_bitCnt     <= '0;
      r_samp0      <= 1'b0;
      r_samp1      <= 1'b0;
      r_sampledBit <= IDLE_LEVEL;
      r_sampValid  <= 1'b0;
      r_bitEnd     <= 1'b0;
    end else if (!dat_samp_en) begin
      r_enD        <= 1'b0;
      r_edgeCnt    <= '0;
      r_bitCnt     <= '0;
      r_samp0      <= 1'b0;
      r_samp1      <= 1'b0;
      r_sampledBit <= IDLE_LEVEL;
      r_sampValid  <= 1'b0;
      r_bitEnd     <= 1'b0;
    end else begin
      r_enD     <= 1'b1;
      r_edgeCnt <= w_cntNxt;
      if (!r_enD) begin
        r_presc <= w_prescIn;
      end
      if (w_wrap) begin
        r_bitCnt <= r_bitCnt + B_ONE;
      end
      if (r_edgeCnt == (w_half - P_ONE)) begin
        r_samp0 <= w_sync;
      end
      if (r_edgeCnt == w_half) begin
        r_samp1 <= w_sync;
      end
      // Strobe and voted bit become visible together at edge_cnt == P/2+2.
      if (r_edgeCnt == (w_half + P_ONE)) begin
        r_sampledBit <= w_maj;
        r_sampValid  <= 1'b1;
      end else begin
        r_sampValid  <= 1'b0;
      end
      r_bitEnd <= (w_cntNxt == w_last);
    end
  end

  assign sampled_bit = r_sampledBit;
  assign samp_valid  = r_sampValid;
  assign bit_end     = r_bitEnd;
  assign bit_cnt     = r_bitCnt;

endmodule

// File: tb/tb_rx_data_sampler.sv
// Directed bench for rx_data_sampler: a vector table for the basic P=8 frame
// plus hand-written sequences for glitches, wrap, disable, prescale and reset.
module tb_rx_data_sampler;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       dat_samp_en;
  logic       sampled_bit;
  logic       samp_valid;
  logic       bit_end;
  logic [3:0] bit_cnt;

  int total = 0;
  int bad   = 0;

  // Synchronized-line value wanted in each enabled cycle of a frame.
  logic lineMap [0:1023];

  typedef struct {
    int         cyc;
    logic       expValid;
    logic       expEnd;
    logic [3:0] expCnt;
    logic       expBit;
  } vec_t;

  vec_t vecs [17];

  rx_data_sampler #(
    .PRESC_W  (6),
    .BITCNT_W (4)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .RX_IN       (RX_IN),
    .prescale    (prescale),
    .dat_samp_en (dat_samp_en),
    .sampled_bit (sampled_bit),
    .samp_valid  (samp_valid),
    .bit_end     (bit_end),
    .bit_cnt     (bit_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle's inputs just after the rising edge, return at the falling edge.
  task automatic applyStimulus(input logic en, input logic rx, input logic [5:0] presc);
    @(posedge CLK);
    #1;
    dat_samp_en = en;
    RX_IN       = rx;
    prescale    = presc;
    @(negedge CLK);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic ev, input logic ee,
                          input logic [3:0] ec, input logic eb);
    checkOutput({tag, " valid"}, 32'(samp_valid), 32'(ev));
    checkOutput({tag, " end"},   32'(bit_end),    32'(ee));
    checkOutput({tag, " cnt"},   32'(bit_cnt),    32'(ec));
    checkOutput({tag, " bit"},   32'(sampled_bit), 32'(eb));
  endtask

  task automatic fillLine(input logic [31:0] bits, input int p, input int nbits);
    for (int c = 0; c < 1024; c++) begin
      lineMap[c] = (c < nbits * p) ? bits[c / p] : 1'b1;
    end
  endtask

  // Runs a full enabled frame; expected timing comes from the effective ratio p.
  task automatic runFrame(input string tag, input logic [5:0] prescIn,
                          input logic [5:0] prescLate, input int switchCyc,
                          input int p, input int nbits, input logic [31:0] expBits);
    logic       expS;
    int         cnt;
    logic [3:0] expCnt;
    applyStimulus(1'b0, lineMap[0], prescIn);
    applyStimulus(1'b0, lineMap[1], prescIn);
    expS = 1'b1;
    for (int k = 0; k < nbits * p; k++) begin
      applyStimulus(1'b1, lineMap[k + 2], (k >= switchCyc) ? prescLate : prescIn);
      cnt    = k % p;
      expCnt = 4'((k / p) % 16);
      if (cnt == p / 2 + 2) expS = expBits[k / p];
      checkAll($sformatf("%s c%0d", tag, k), (cnt == p / 2 + 2), (cnt == p - 1), expCnt, expS);
    end
    applyStimulus(1'b0, 1'b1, prescIn);
    checkOutput({tag, " fall valid"}, 32'(samp_valid), 32'd0);
    checkOutput({tag, " fall end"},   32'(bit_end),    32'd0);
    applyStimulus(1'b0, 1'b1, prescIn);
    checkAll({tag, " idle"}, 1'b0, 1'b0, 4'd0, 1'b1);
  endtask

  initial begin
    RST         = 1'b1;
    dat_samp_en = 1'b0;
    RX_IN       = 1'b1;
    prescale    = 6'd8;

    #2;
    checkAll("in reset", 1'b0, 1'b0, 4'd0, 1'b1);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    applyStimulus(1'b0, 1'b1, 6'd8);
    checkAll("post reset", 1'b0, 1'b0, 4'd0, 1'b1);

    // P=8, line held 0: strobe at 6 and 14, bit_end at 7 and 15, bit_cnt steps at 8, 16.
    vecs[0]  = '{0,  1'b0, 1'b0, 4'd0, 1'b1};
    vecs[1]  = '{1,  1'b0, 1'b0, 4'd0, 1'b1};
    vecs[2]  = '{2,  1'b0, 1'b0, 4'd0, 1'b1};
    vecs[3]  = '{3,  1'b0, 1'b0, 4'd0, 1'b1};
    vecs[4]  = '{4,  1'b0, 1'b0, 4'd0, 1'b1};
    vecs[5]  = '{5,  1'b0, 1'b0, 4'd0, 1'b1};
    vecs[6]  = '{6,  1'b1, 1'b0, 4'd0, 1'b0};
    vecs[7]  = '{7,  1'b0, 1'b1, 4'd0, 1'b0};
    vecs[8]  = '{8,  1'b0, 1'b0, 4'd1, 1'b0};
    vecs[9]  = '{9,  1'b0, 1'b0, 4'd1, 1'b0};
    vecs[10] = '{10, 1'b0, 1'b0, 4'd1, 1'b0};
    vecs[11] = '{11, 1'b0, 1'b0, 4'd1, 1'b0};
    vecs[12] = '{12, 1'b0, 1'b0, 4'd1, 1'b0};
    vecs[13] = '{13, 1'b0, 1'b0, 4'd1, 1'b0};
    vecs[14] = '{14, 1'b1, 1'b0, 4'd1, 1'b0};
    vecs[15] = '{15, 1'b0, 1'b1, 4'd1, 1'b0};
    vecs[16] = '{16, 1'b0, 1'b0, 4'd2, 1'b0};
    applyStimulus(1'b0, 1'b0, 6'd8);
    applyStimulus(1'b0, 1'b0, 6'd8);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(1'b1, 1'b0, 6'd8);
      checkAll($sformatf("tbl c%0d", vecs[i].cyc), vecs[i].expValid, vecs[i].expEnd,
               vecs[i].expCnt, vecs[i].expBit);
    end
    applyStimulus(1'b0, 1'b1, 6'd8);
    applyStimulus(1'b0, 1'b1, 6'd8);
    checkAll("tbl idle", 1'b0, 1'b0, 4'd0, 1'b1);

    // P=16: single-cycle glitch votes 0, two-cycle glitch votes 1.
    fillLine(32'h0, 16, 2);
    lineMap[8]  = 1'b1;
    lineMap[24] = 1'b1;
    lineMap[25] = 1'b1;
    runFrame("glitch", 6'd16, 6'd16, 99999, 16, 2, 32'h2);

    // P=32, 17 alternating bits: covers every bit_cnt value and the 15->0 wrap.
    fillLine(32'hAAAAAAAA, 32, 17);
    runFrame("p32", 6'd32, 6'd32, 99999, 32, 17, 32'hAAAAAAAA);

    // Disable at edge_cnt=5 of bit 1 (P=16), then re-enable from bit 0.
    applyStimulus(1'b0, 1'b0, 6'd16);
    applyStimulus(1'b0, 1'b0, 6'd16);
    for (int k = 0; k < 21; k++) applyStimulus(1'b1, 1'b0, 6'd16);
    applyStimulus(1'b0, 1'b0, 6'd16);
    checkAll("drop cycle", 1'b0, 1'b0, 4'd1, 1'b0);
    applyStimulus(1'b0, 1'b0, 6'd16);
    checkAll("after drop", 1'b0, 1'b0, 4'd0, 1'b1);
    fillLine(32'h1, 16, 2);
    runFrame("reen", 6'd16, 6'd16, 99999, 16, 2, 32'h1);

    // Mid-frame prescale change is ignored; an illegal ratio runs as 8.
    fillLine(32'h5, 8, 3);
    runFrame("chg", 6'd8, 6'd16, 5, 8, 3, 32'h5);
    fillLine(32'h2, 8, 3);
    runFrame("p12", 6'd12, 6'd12, 99999, 8, 3, 32'h2);

    // Asynchronous reset between clock edges.
    applyStimulus(1'b0, 1'b0, 6'd8);
    applyStimulus(1'b0, 1'b0, 6'd8);
    for (int k = 0; k < 10; k++) applyStimulus(1'b1, 1'b0, 6'd8);
    checkAll("pre reset", 1'b0, 1'b0, 4'd1, 1'b0);
    #1 RST = 1'b1;
    #1;
    checkAll("async reset", 1'b0, 1'b0, 4'd0, 1'b1);
    dat_samp_en = 1'b0;
    #1 RST = 1'b0;
    applyStimulus(1'b0, 1'b1, 6'd8);
    checkAll("reset release", 1'b0, 1'b0, 4'd0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
